// File: rtl/wptr_full_ctrl_if.sv
// Write-side bus of the async FIFO pointer controller: the producer request, the
// synchronized read pointer, and everything the controller reports back.
interface wptr_full_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 9
);
    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic            w_en;
    logic            ovf_clr;
    logic [PW-1:0]   rptr_gray_sync;
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   wptr_gray;
    logic [ADDR_WIDTH-1:0] waddr;
    logic            mem_we;
    logic            f_full;
    logic            f_afull;
    logic [PW-1:0]   w_level;
    logic            overflow;

    // Producer / read-pointer synchronizer side
    modport master (
        output w_en, ovf_clr, rptr_gray_sync,
        input  wptr, wptr_gray, waddr, mem_we, f_full, f_afull, w_level, overflow
    );

    // Controller side
    modport slave (
        input  w_en, ovf_clr, rptr_gray_sync,
        output wptr, wptr_gray, waddr, mem_we, f_full, f_afull, w_level, overflow
    );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and full-flag controller for the dual-clock FIFO.
// Keeps a binary write pointer plus a registered Gray copy for the read side, and derives
// full, almost-full, fill level and a sticky overflow flag from the synchronized read pointer.
// Every flag is registered, so rptr_gray_sync never reaches an output combinationally.
module wptr_full_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned AFULL_THRESH = 500
) (
    input logic            w_clk,
    input logic            wrst,
    wptr_full_ctrl_if.slave bus
);
    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wptr_q,  wptr_d;
    logic [PW-1:0] gray_q,  gray_d;
    logic [PW-1:0] level_q, level_d;
    logic          full_q,  full_d;
    logic          afull_q, afull_d;
    logic          ovf_q,   ovf_d;

    logic          accept;
    logic [PW-1:0] rgray;
    logic [PW-1:0] rbin;
    logic [PW-1:0] full_pattern;

    assign rgray = bus.rptr_gray_sync;

    // Gray-to-binary of the synchronized read pointer: XOR prefix from the MSB down
    always_comb begin
        rbin = '0;
        rbin[PW-1] = rgray[PW-1];
        for (int i = int'(PW) - 2; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ rgray[i];
        end
    end

    // Write is full when our Gray pointer equals the read pointer with its top two bits inverted
    assign full_pattern = {~rgray[PW-1:PW-2], rgray[PW-3:0]};

    // Next-state: pointer advance, Gray encode, flags and level from the post-write pointer
    always_comb begin
        accept  = bus.w_en & ~full_q;
        wptr_d  = wptr_q + PW'(accept);
        gray_d  = (wptr_d >> 1) ^ wptr_d;
        level_d = wptr_d - rbin;
        full_d  = (gray_d == full_pattern);
        afull_d = (32'(level_d) >= AFULL_THRESH);
        // A rejected write outranks a simultaneous clear
        ovf_d   = (bus.w_en & full_q) | (ovf_q & ~bus.ovf_clr);
    end

    // State registers, asynchronously cleared
    always_ff @(posedge w_clk or posedge wrst) begin
        if (wrst) begin
            wptr_q  <= '0;
            gray_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            gray_q  <= gray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.wptr      = wptr_q;
    assign bus.wptr_gray = gray_q;
    assign bus.waddr     = wptr_q[ADDR_WIDTH-1:0];
    assign bus.mem_we    = accept;
    assign bus.f_full    = full_q;
    assign bus.f_afull   = afull_q;
    assign bus.w_level   = level_q;
    assign bus.overflow  = ovf_q;

    // Full implies a level of the whole depth, which always clears the almost-full threshold
    assert property (@(posedge w_clk) disable iff (wrst) full_q |-> afull_q);

endmodule
